// File: rtl/dma_copy.sv
// dma_copy: word-copy DMA engine.
//   Responder side (register file, single-cycle ready):
//     clk, reset (async, active-low), address_in, sel_in, read_in, read_value_out,
//     write_mask_in, write_value_in, ready_out
//   Initiator side (one beat at a time, held until dma_ready_in):
//     dma_address_out, dma_read_out, dma_write_out, dma_read_value_in,
//     dma_write_mask_out, dma_write_value_out, dma_ready_in, dma_fault_in
//   irq_out: registered level interrupt, IRQ_EN & (done | error).
// Register map (address_in[3:2]): 0 SRC, 1 DST, 2 LEN, 3 CTRL.
module dma_copy #(
   parameter int unsigned LEN_WIDTH = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] address_in,
   input  logic        sel_in,
   input  logic        read_in,
   output logic [31:0] read_value_out,
   input  logic [3:0]  write_mask_in,
   input  logic [31:0] write_value_in,
   output logic        ready_out,
   output logic [31:0] dma_address_out,
   output logic        dma_read_out,
   output logic        dma_write_out,
   input  logic [31:0] dma_read_value_in,
   output logic [3:0]  dma_write_mask_out,
   output logic [31:0] dma_write_value_out,
   input  logic        dma_ready_in,
   input  logic        dma_fault_in,
   output logic        irq_out
);

   typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

   state_e               state_q, state_d;
   logic [31:0]          src_q, src_d, dst_q, dst_d, buf_q, buf_d;
   logic [LEN_WIDTH-1:0] len_q, len_d;
   logic                 done_q, done_d, error_q, error_d, aborted_q, aborted_d;
   logic                 irq_en_q, irq_en_d, abort_pend_q, abort_pend_d, irq_q, irq_d;

   logic       busy, wr_en, ctrl_wr, start, abort_wr, clr;
   logic [1:0] reg_sel;
   logic       unused_addr;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wdata,
                                         input logic [3:0] mask);
      logic [31:0] res;
      res = old;
      for (int i = 0; i < 4; i++) begin
         if (mask[i]) res[8*i +: 8] = wdata[8*i +: 8];
      end
      return res;
   endfunction

   assign unused_addr = ^{address_in[31:4], address_in[1:0]};
   assign reg_sel     = address_in[3:2];
   assign busy        = (state_q != StIdle);
   assign wr_en       = sel_in & (|write_mask_in);
   // All CTRL command bits live in byte lane 0.
   assign ctrl_wr     = wr_en & (reg_sel == 2'd3) & write_mask_in[0];
   assign start       = ctrl_wr & write_value_in[0];
   assign abort_wr    = ctrl_wr & write_value_in[1];
   assign clr         = ctrl_wr & write_value_in[3];
   assign ready_out   = sel_in;
   assign irq_out     = irq_q;

   // Combinational read so a CTRL read alongside START returns pre-write status.
   always_comb begin
      read_value_out = '0;
      if (sel_in && read_in) begin
         unique case (reg_sel)
            2'd0:    read_value_out = src_q;
            2'd1:    read_value_out = dst_q;
            2'd2:    read_value_out = 32'(len_q);
            default: read_value_out = {27'b0, irq_en_q, aborted_q, error_q, done_q, busy};
         endcase
      end
   end

   always_comb begin
      state_d             = state_q;
      src_d               = src_q;
      dst_d               = dst_q;
      len_d               = len_q;
      buf_d               = buf_q;
      done_d              = done_q;
      error_d             = error_q;
      aborted_d           = aborted_q;
      irq_en_d            = irq_en_q;
      abort_pend_d        = abort_pend_q;
      dma_read_out        = 1'b0;
      dma_write_out       = 1'b0;
      dma_address_out     = '0;
      dma_write_mask_out  = 4'b0000;
      dma_write_value_out = '0;

      if (ctrl_wr) irq_en_d = write_value_in[2];
      if (clr) begin
         done_d  = 1'b0;
         error_d = 1'b0;
      end

      // Pointer/length registers are frozen while a copy is running.
      if (!busy && wr_en) begin
         unique case (reg_sel)
            2'd0:    src_d = merge(src_q, write_value_in, write_mask_in) & 32'hFFFF_FFFC;
            2'd1:    dst_d = merge(dst_q, write_value_in, write_mask_in) & 32'hFFFF_FFFC;
            2'd2:    len_d = LEN_WIDTH'(merge(32'(len_q), write_value_in, write_mask_in));
            default: ;
         endcase
      end

      unique case (state_q)
         StIdle: begin
            abort_pend_d = 1'b0;
            if (start) begin
               done_d    = 1'b0;
               error_d   = 1'b0;
               aborted_d = 1'b0;
               if (len_q == '0) done_d  = 1'b1;
               else             state_d = StRead;
            end
         end
         StRead: begin
            dma_read_out    = 1'b1;
            dma_address_out = src_q;
            if (abort_wr) abort_pend_d = 1'b1;
            if (dma_ready_in) begin
               if (dma_fault_in) begin
                  error_d = 1'b1;
                  state_d = StIdle;
               end else begin
                  buf_d   = dma_read_value_in;
                  state_d = StWrite;
               end
            end
         end
         StWrite: begin
            dma_write_out       = 1'b1;
            dma_address_out     = dst_q;
            dma_write_mask_out  = 4'b1111;
            dma_write_value_out = buf_q;
            if (abort_wr) abort_pend_d = 1'b1;
            if (dma_ready_in) begin
               if (dma_fault_in) begin
                  error_d = 1'b1;
                  state_d = StIdle;
               end else begin
                  src_d = src_q + 32'd4;
                  dst_d = dst_q + 32'd4;
                  len_d = len_q - LEN_WIDTH'(1);
                  if (len_q == LEN_WIDTH'(1)) begin
                     done_d  = 1'b1;
                     state_d = StIdle;
                  end else if (abort_pend_q || abort_wr) begin
                     aborted_d = 1'b1;
                     state_d   = StIdle;
                  end else begin
                     state_d = StRead;
                  end
               end
            end
         end
         default: state_d = StIdle;
      endcase

      irq_d = irq_en_d & (done_d | error_d);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= StIdle;
         src_q        <= '0;
         dst_q        <= '0;
         len_q        <= '0;
         buf_q        <= '0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         aborted_q    <= 1'b0;
         irq_en_q     <= 1'b0;
         abort_pend_q <= 1'b0;
         irq_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         src_q        <= src_d;
         dst_q        <= dst_d;
         len_q        <= len_d;
         buf_q        <= buf_d;
         done_q       <= done_d;
         error_q      <= error_d;
         aborted_q    <= aborted_d;
         irq_en_q     <= irq_en_d;
         abort_pend_q <= abort_pend_d;
         irq_q        <= irq_d;
      end
   end

endmodule

// File: tb/tb_dma_copy.sv
module tb_dma_copy;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] address_in = '0;
   logic        sel_in = 1'b0, read_in = 1'b0;
   logic [31:0] read_value_out;
   logic [3:0]  write_mask_in = '0;
   logic [31:0] write_value_in = '0;
   logic        ready_out;
   logic [31:0] dma_address_out;
   logic        dma_read_out, dma_write_out;
   logic [31:0] dma_read_value_in;
   logic [3:0]  dma_write_mask_out;
   logic [31:0] dma_write_value_out;
   logic        dma_ready_in, dma_fault_in;
   logic        irq_out;

   dma_copy #(.LEN_WIDTH(16)) dut (
      .clk                 (clk),
      .reset               (rst_n),
      .address_in          (address_in),
      .sel_in              (sel_in),
      .read_in             (read_in),
      .read_value_out      (read_value_out),
      .write_mask_in       (write_mask_in),
      .write_value_in      (write_value_in),
      .ready_out           (ready_out),
      .dma_address_out     (dma_address_out),
      .dma_read_out        (dma_read_out),
      .dma_write_out       (dma_write_out),
      .dma_read_value_in   (dma_read_value_in),
      .dma_write_mask_out  (dma_write_mask_out),
      .dma_write_value_out (dma_write_value_out),
      .dma_ready_in        (dma_ready_in),
      .dma_fault_in        (dma_fault_in),
      .irq_out             (irq_out)
   );

   always #5 clk = ~clk;

   // ---------------- memory model (read data is a fixed function of address) ----------------
   function automatic logic [31:0] pat(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   int          wait_cfg = 0;
   int          fault_read_no = -1;
   int          wait_cnt = 0;
   int          n_reads = 0, n_writes = 0, stable_err = 0;
   logic [31:0] log_addr [128];
   logic [31:0] log_data [128];
   logic        pend_q = 1'b0;
   logic [69:0] cap_q = '0;

   assign dma_ready_in      = (dma_read_out | dma_write_out) && (wait_cnt >= wait_cfg);
   assign dma_fault_in      = dma_ready_in && dma_read_out && (n_reads == fault_read_no);
   assign dma_read_value_in = pat(dma_address_out);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= 0;
         pend_q   <= 1'b0;
      end else begin
         if (pend_q && (cap_q != {dma_address_out, dma_read_out, dma_write_out,
                                  dma_write_mask_out, dma_write_value_out}))
            stable_err <= stable_err + 1;
         pend_q <= (dma_read_out | dma_write_out) & ~dma_ready_in;
         cap_q  <= {dma_address_out, dma_read_out, dma_write_out, dma_write_mask_out,
                    dma_write_value_out};
         if (dma_read_out | dma_write_out) begin
            if (dma_ready_in) begin
               wait_cnt <= 0;
               if (dma_read_out) n_reads <= n_reads + 1;
               else begin
                  log_addr[n_writes % 128] <= dma_address_out;
                  log_data[n_writes % 128] <= dma_write_value_out;
                  n_writes <= n_writes + 1;
               end
            end else begin
               wait_cnt <= wait_cnt + 1;
            end
         end
      end
   end

   // ---------------- checking ----------------
   int vec_cnt = 0, miss_cnt = 0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;
   wr_t exp_q[$];
   int  wr_base, rd_base;

   typedef struct {
      string       name;
      logic [1:0]  r;
      logic [3:0]  mask;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;
   vec_t vecs[11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
      end
   endtask

   task automatic bus_write(input logic [1:0] r, input logic [3:0] m, input logic [31:0] d);
      @(negedge clk);
      sel_in = 1'b1; read_in = 1'b0; address_in = {28'h0, r, 2'b00};
      write_mask_in = m; write_value_in = d;
      @(negedge clk);
      sel_in = 1'b0; write_mask_in = '0; write_value_in = '0; address_in = '0;
   endtask

   // Zero-time read, called between clock edges.
   task automatic bus_read(input logic [1:0] r, output logic [31:0] d);
      sel_in = 1'b1; read_in = 1'b1; address_in = {28'h0, r, 2'b00};
      #1 d = read_value_out;
      sel_in = 1'b0; read_in = 1'b0; address_in = '0;
   endtask

   task automatic check_reg(input string name, input logic [1:0] r, input logic [31:0] exp);
      logic [31:0] v;
      bus_read(r, v);
      check(name, v, exp);
   endtask

   task automatic wait_idle(input string name, output int cyc);
      logic [31:0] v;
      logic        found;
      found = 1'b0;
      cyc   = 0;
      for (int k = 0; k < 2000 && !found; k++) begin
         bus_read(2'd3, v);
         if (!v[0]) found = 1'b1;
         else begin
            @(negedge clk);
            cyc++;
         end
      end
      check({name, " idle reached"}, {31'b0, found}, 32'd1);
   endtask

   task automatic start_copy(input logic [31:0] s, input logic [31:0] d, input logic [31:0] n,
                             input int n_exp, input logic [31:0] ctrl);
      bus_write(2'd0, 4'hF, s);
      bus_write(2'd1, 4'hF, d);
      bus_write(2'd2, 4'hF, n);
      exp_q.delete();
      for (int i = 0; i < n_exp; i++) exp_q.push_back('{d + 32'(4 * i), pat(s + 32'(4 * i))});
      wr_base = n_writes;
      rd_base = n_reads;
      bus_write(2'd3, 4'h1, ctrl);
   endtask

   task automatic check_writes(input string name);
      int got, k;
      wr_t e;
      got = n_writes - wr_base;
      check({name, " write count"}, 32'(got), 32'(exp_q.size()));
      k = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (k < got) begin
            check({name, " write addr"}, log_addr[(wr_base + k) % 128], e.addr);
            check({name, " write data"}, log_data[(wr_base + k) % 128], e.data);
         end
         k++;
      end
   endtask

   initial begin
      int          cyc;
      logic        found;
      logic [31:0] v;

      vecs[0]  = '{"src full",      2'd0, 4'hF, 32'h1234_5677, 32'h1234_5674};
      vecs[1]  = '{"dst full",      2'd1, 4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFC};
      vecs[2]  = '{"len full",      2'd2, 4'hF, 32'hABCD_1234, 32'h0000_1234};
      vecs[3]  = '{"src clear",     2'd0, 4'hF, 32'h0000_0000, 32'h0000_0000};
      vecs[4]  = '{"src lane1",     2'd0, 4'h2, 32'h0000_AB00, 32'h0000_AB00};
      vecs[5]  = '{"dst lane0",     2'd1, 4'h1, 32'h0000_0077, 32'hFFFF_FF74};
      vecs[6]  = '{"len upper",     2'd2, 4'hC, 32'hFFFF_0000, 32'h0000_1234};
      vecs[7]  = '{"len lane1",     2'd2, 4'h2, 32'h0000_5600, 32'h0000_5634};
      vecs[8]  = '{"ctrl irq_en",   2'd3, 4'hF, 32'h0000_0004, 32'h0000_0010};
      vecs[9]  = '{"ctrl off",      2'd3, 4'hF, 32'h0000_0000, 32'h0000_0000};
      vecs[10] = '{"abort in idle", 2'd3, 4'hF, 32'h0000_0002, 32'h0000_0000};

      rst_n = 1'b0;
      #1;
      check("rst dma_read", {31'b0, dma_read_out}, 32'd0);
      check("rst dma_write", {31'b0, dma_write_out}, 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_reg("rst src", 2'd0, 32'd0);
      check_reg("rst dst", 2'd1, 32'd0);
      check_reg("rst len", 2'd2, 32'd0);
      check_reg("rst ctrl", 2'd3, 32'd0);
      check("rst addr", dma_address_out, 32'd0);
      check("rst mask", {28'b0, dma_write_mask_out}, 32'd0);
      check("rst wvalue", dma_write_value_out, 32'd0);
      check("rst irq", {31'b0, irq_out}, 32'd0);

      // Responder bus behaviour when not selected.
      read_in = 1'b1; address_in = 32'h8;
      #1 check("unselected rdata", read_value_out, 32'd0);
      check("unselected ready", {31'b0, ready_out}, 32'd0);
      sel_in = 1'b1;
      #1 check("selected ready", {31'b0, ready_out}, 32'd1);
      sel_in = 1'b0; read_in = 1'b0; address_in = '0;

      // Register write/readback table.
      for (int i = 0; i < 11; i++) begin
         bus_write(vecs[i].r, vecs[i].mask, vecs[i].wdata);
         check_reg(vecs[i].name, vecs[i].r, vecs[i].exp);
      end

      // 1: zero-wait copy of 4 words, 2 cycles per word.
      wait_cfg = 0;
      start_copy(32'h100, 32'h200, 32'd4, 4, 32'h1);
      wait_idle("t1", cyc);
      check("t1 cycles", 32'(cyc), 32'd8);
      check_reg("t1 ctrl", 2'd3, 32'h2);
      check_reg("t1 len", 2'd2, 32'd0);
      check_reg("t1 src", 2'd0, 32'h110);
      check_reg("t1 dst", 2'd1, 32'h210);
      check("t1 reads", 32'(n_reads - rd_base), 32'd4);
      check_writes("t1");

      // 2: LEN=0 completes at once with no bus traffic.
      start_copy(32'h100, 32'h200, 32'd0, 0, 32'h1);
      check_reg("t2 ctrl", 2'd3, 32'h2);
      repeat (4) @(negedge clk);
      check("t2 reads", 32'(n_reads - rd_base), 32'd0);
      check_writes("t2");

      // 3: three wait cycles per beat, requests must hold steady.
      wait_cfg = 3;
      start_copy(32'h140, 32'h240, 32'd3, 3, 32'h1);
      wait_idle("t3", cyc);
      check("t3 cycles", 32'(cyc), 32'd24);
      check("t3 stable", 32'(stable_err), 32'd0);
      check_writes("t3");

      // 4: fault on the second read.
      wait_cfg = 0;
      fault_read_no = n_reads + 1;
      start_copy(32'h100, 32'h300, 32'd5, 1, 32'h5);
      wait_idle("t4", cyc);
      fault_read_no = -1;
      check_reg("t4 ctrl", 2'd3, 32'h14);
      check_reg("t4 len", 2'd2, 32'd4);
      check_reg("t4 src", 2'd0, 32'h104);
      check_reg("t4 dst", 2'd1, 32'h304);
      check("t4 reads", 32'(n_reads - rd_base), 32'd2);
      check("t4 irq set", {31'b0, irq_out}, 32'd1);
      check_writes("t4");
      bus_write(2'd3, 4'h1, 32'hC);
      check("t4 irq clr", {31'b0, irq_out}, 32'd0);
      check_reg("t4 ctrl clr", 2'd3, 32'h10);

      // 5: ABORT while word 2 is being read; word 2 is still written.
      wait_cfg = 2;
      start_copy(32'h180, 32'h280, 32'd6, 2, 32'h1);
      found = 1'b0;
      for (int k = 0; k < 200 && !found; k++) begin
         @(negedge clk);
         if (dma_read_out && (n_reads == rd_base + 1)) found = 1'b1;
      end
      check("t5 reached read 2", {31'b0, found}, 32'd1);
      bus_write(2'd3, 4'h1, 32'h2);
      wait_idle("t5", cyc);
      check_reg("t5 ctrl", 2'd3, 32'h8);
      check_reg("t5 len", 2'd2, 32'd4);
      check_reg("t5 src", 2'd0, 32'h188);
      check_writes("t5");

      // 6: pointer/length writes while busy are ignored.
      wait_cfg = 3;
      start_copy(32'h100, 32'h200, 32'd6, 6, 32'h1);
      bus_write(2'd0, 4'hF, 32'hDEAD_0000);
      bus_write(2'd1, 4'hF, 32'hBEEF_0000);
      bus_write(2'd2, 4'hF, 32'd1);
      wait_idle("t6", cyc);
      check_reg("t6 src", 2'd0, 32'h118);
      check_reg("t6 dst", 2'd1, 32'h218);
      check_reg("t6 len", 2'd2, 32'd0);
      check_reg("t6 ctrl", 2'd3, 32'h2);
      check_writes("t6");
      bus_write(2'd0, 4'hF, 32'h0);
      bus_write(2'd0, 4'h2, 32'h0000_00AB << 8);
      check_reg("t6 byte src", 2'd0, 32'h0000_AB00);

      // Reset asserted mid-write clears everything asynchronously.
      start_copy(32'h100, 32'h200, 32'd6, 0, 32'h5);
      found = 1'b0;
      for (int k = 0; k < 200 && !found; k++) begin
         @(negedge clk);
         if (dma_write_out) found = 1'b1;
      end
      check("t6 reached write", {31'b0, found}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("t6 rst write", {31'b0, dma_write_out}, 32'd0);
      check("t6 rst read", {31'b0, dma_read_out}, 32'd0);
      check("t6 rst addr", dma_address_out, 32'd0);
      check("t6 rst mask", {28'b0, dma_write_mask_out}, 32'd0);
      check("t6 rst wvalue", dma_write_value_out, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_reg("t6 rst src", 2'd0, 32'd0);
      check_reg("t6 rst dst", 2'd1, 32'd0);
      check_reg("t6 rst len", 2'd2, 32'd0);
      check_reg("t6 rst ctrl", 2'd3, 32'd0);
      repeat (3) @(negedge clk);
      check("t6 idle after rst", {30'b0, dma_read_out, dma_write_out}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
